// File: rtl/risc_pkg.sv
// Shared core types: decode control fields, LSU state and access-size helpers.
// Purely declarative; no timing or flow control of its own.
package risc_pkg;

  // 2'b10 is deliberately unused so a corrupted size field is caught as a fault.
  typedef enum logic [1:0] {
    BYTE      = 2'b00,
    HALF_WORD = 2'b01,
    WORD      = 2'b11
  } mem_size_t;

  typedef struct packed {
    logic      mem_valid;
    logic      mem_write;
    mem_size_t mem_size;
    logic      load_zero_extend;
  } control_t;

  typedef enum logic [1:0] {
    IDLE,
    BUS_REQ,
    WAIT_RSP,
    DONE
  } lsu_state_t;

  localparam logic [3:0] BE_WORD = 4'b1111;

  function automatic logic lsu_fault(input logic [1:0] size, input logic [1:0] off);
    case (size)
      BYTE:      return 1'b0;
      HALF_WORD: return off[0];
      WORD:      return off != 2'b00;
      default:   return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lsu_byte_en(input logic [1:0] size, input logic [1:0] off);
    case (size)
      BYTE:      return 4'b0001 << off;
      HALF_WORD: return 4'b0011 << off;
      default:   return BE_WORD;
    endcase
  endfunction

  function automatic logic [31:0] lsu_store_data(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      BYTE:      return {4{wdata[7:0]}};
      HALF_WORD: return {2{wdata[15:0]}};
      default:   return wdata;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load lane select and sign/zero extension of a bus read word.
// Latency: combinational; backpressure: none.
module lsu_load_align
  import risc_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        zero_ext,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = rdata[{addr_lo, 3'b000} +: 8];
  assign lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data = rdata;
    case (size)
      BYTE:      data = {{24{~zero_ext & lane_b[7]}}, lane_b};
      HALF_WORD: data = {{16{~zero_ext & lane_h[15]}}, lane_h};
      default:   data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: one aligned bus transaction per access.
// Latency: load 3 cycles + bus waits, store 2 + waits, fault 1; req_ready low while busy.
module load_store_unit
  import risc_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_zero_ext,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [4:0]            req_rd,
  output logic                  bus_req_valid,
  input  logic                  bus_req_ready,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic                  bus_we,
  output logic [3:0]            bus_be,
  output logic [31:0]           bus_wdata,
  input  logic                  bus_rsp_valid,
  input  logic [31:0]           bus_rdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic [4:0]            rsp_rd,
  output logic                  rsp_write,
  output logic                  rsp_fault,
  output logic                  busy
);

  if (DATA_WIDTH != 32) begin : g_width_check
    $error("load_store_unit supports only a 32-bit data bus");
  end

  lsu_state_t  state;
  logic [1:0]  lat_size;
  logic [1:0]  lat_off;
  logic        lat_zext;
  logic [31:0] load_data;

  lsu_load_align u_align (
    .rdata    (bus_rdata),
    .addr_lo  (lat_off),
    .size     (lat_size),
    .zero_ext (lat_zext),
    .data     (load_data)
  );

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      lat_size      <= 2'b00;
      lat_off       <= 2'b00;
      lat_zext      <= 1'b0;
      bus_req_valid <= 1'b0;
      bus_addr      <= '0;
      bus_we        <= 1'b0;
      bus_be        <= 4'b0000;
      bus_wdata     <= 32'h0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= 32'h0;
      rsp_rd        <= 5'd0;
      rsp_write     <= 1'b0;
      rsp_fault     <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_size <= req_size;
            lat_off  <= req_addr[1:0];
            lat_zext <= req_zero_ext;
            rsp_rd   <= req_rd;
            if (lsu_fault(req_size, req_addr[1:0])) begin
              // Faulting accesses never touch the bus.
              state     <= DONE;
              rsp_valid <= 1'b1;
              rsp_fault <= 1'b1;
              rsp_write <= req_write;
              rsp_rdata <= 32'h0;
            end else begin
              state         <= BUS_REQ;
              bus_req_valid <= 1'b1;
              bus_addr      <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
              bus_we        <= req_write;
              bus_be        <= lsu_byte_en(req_size, req_addr[1:0]);
              bus_wdata     <= lsu_store_data(req_size, req_wdata);
            end
          end
        end
        BUS_REQ: begin
          if (bus_req_ready) begin
            bus_req_valid <= 1'b0;
            if (bus_we) begin
              state     <= DONE;
              rsp_valid <= 1'b1;
              rsp_fault <= 1'b0;
              rsp_write <= 1'b1;
              rsp_rdata <= 32'h0;
            end else begin
              state <= WAIT_RSP;
            end
          end
        end
        WAIT_RSP: begin
          if (bus_rsp_valid) begin
            state     <= DONE;
            rsp_valid <= 1'b1;
            rsp_fault <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= load_data;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, loads, faults, backpressure, async reset.
module tb_load_store_unit;
  import risc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_zero_ext;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        bus_req_valid, bus_req_ready, bus_we, bus_rsp_valid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        rsp_valid, rsp_write, rsp_fault, busy;
  logic [31:0] rsp_rdata;
  logic [4:0]  rsp_rd;

  int errors = 0;
  int checks = 0;

  load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_zero_ext(req_zero_ext), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_addr(bus_addr),
    .bus_we(bus_we), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_rsp_valid(bus_rsp_valid), .bus_rdata(bus_rdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_rd(rsp_rd),
    .rsp_write(rsp_write), .rsp_fault(rsp_fault), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single edge; returns at cycle 1 (+1 time unit).
  task automatic issue(input logic w, input logic [1:0] sz, input logic zx,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
    chk("issue_ready", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_zero_ext = zx;
    req_addr = a; req_wdata = d; req_rd = rd;
    step();
    req_valid = 1'b0;
  endtask

  task automatic do_store(input string tag, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] d, input logic [4:0] rd,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata);
    issue(1'b1, sz, 1'b0, a, d, rd);
    chk({tag, "_breq"},  {31'b0, bus_req_valid}, 32'd1);
    chk({tag, "_baddr"}, bus_addr, exp_addr);
    chk({tag, "_be"},    {28'b0, bus_be}, {28'b0, exp_be});
    chk({tag, "_wdata"}, bus_wdata, exp_wdata);
    chk({tag, "_we"},    {31'b0, bus_we}, 32'd1);
    chk({tag, "_rdy0"},  {31'b0, req_ready}, 32'd0);
    step();
    chk({tag, "_rspv"},  {31'b0, rsp_valid}, 32'd1);
    chk({tag, "_rspw"},  {31'b0, rsp_write}, 32'd1);
    chk({tag, "_rspd"},  rsp_rdata, 32'h0);
    chk({tag, "_rd"},    {27'b0, rsp_rd}, {27'b0, rd});
    step();
    chk({tag, "_pulse"}, {31'b0, rsp_valid}, 32'd0);
  endtask

  task automatic do_load(input string tag, input logic [1:0] sz, input logic zx,
                         input logic [31:0] a, input logic [31:0] word, input logic [4:0] rd,
                         input logic [3:0] exp_be, input logic [31:0] exp_data);
    issue(1'b0, sz, zx, a, 32'h0, rd);
    chk({tag, "_breq"},  {31'b0, bus_req_valid}, 32'd1);
    chk({tag, "_baddr"}, bus_addr, {a[31:2], 2'b00});
    chk({tag, "_be"},    {28'b0, bus_be}, {28'b0, exp_be});
    chk({tag, "_we"},    {31'b0, bus_we}, 32'd0);
    step();
    chk({tag, "_wait"},  {31'b0, rsp_valid}, 32'd0);
    bus_rsp_valid = 1'b1; bus_rdata = word;
    step();
    bus_rsp_valid = 1'b0; bus_rdata = 32'h0;
    chk({tag, "_rspv"},  {31'b0, rsp_valid}, 32'd1);
    chk({tag, "_data"},  rsp_rdata, exp_data);
    chk({tag, "_rd"},    {27'b0, rsp_rd}, {27'b0, rd});
    chk({tag, "_rspw"},  {31'b0, rsp_write}, 32'd0);
    chk({tag, "_flt"},   {31'b0, rsp_fault}, 32'd0);
    step();
    chk({tag, "_pulse"}, {31'b0, rsp_valid}, 32'd0);
  endtask

  task automatic do_fault(input string tag, input logic [1:0] sz, input logic [31:0] a,
                          input logic [4:0] rd);
    issue(1'b0, sz, 1'b0, a, 32'h0, rd);
    chk({tag, "_rspv"}, {31'b0, rsp_valid}, 32'd1);
    chk({tag, "_flt"},  {31'b0, rsp_fault}, 32'd1);
    chk({tag, "_data"}, rsp_rdata, 32'h0);
    chk({tag, "_breq"}, {31'b0, bus_req_valid}, 32'd0);
    step();
    chk({tag, "_pulse"}, {31'b0, rsp_valid}, 32'd0);
    chk({tag, "_breq2"}, {31'b0, bus_req_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_zero_ext = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
    bus_req_ready = 1'b1; bus_rsp_valid = 1'b0; bus_rdata = 32'h0;
    #12;
    chk("rst_breq",  {31'b0, bus_req_valid}, 32'd0);
    chk("rst_rspv",  {31'b0, rsp_valid}, 32'd0);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_busy",  {31'b0, busy}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    rst = 1'b0;
    step();

    do_store("sb", BYTE,      32'h0000_1003, 32'h0000_00A5, 5'd3,
             32'h0000_1000, 4'b1000, 32'hA5A5_A5A5);
    do_store("sh", HALF_WORD, 32'h0000_1002, 32'h1234_BEEF, 5'd4,
             32'h0000_1000, 4'b1100, 32'hBEEF_BEEF);
    do_store("sw", WORD,      32'h0000_1004, 32'hDEAD_BEEF, 5'd5,
             32'h0000_1004, 4'b1111, 32'hDEAD_BEEF);

    do_load("lb",   BYTE,      1'b0, 32'h0000_2001, 32'h0000_80FF, 5'd10, 4'b0010, 32'hFFFF_FF80);
    do_load("lbu",  BYTE,      1'b1, 32'h0000_2001, 32'h0000_80FF, 5'd11, 4'b0010, 32'h0000_0080);
    do_load("lb0",  BYTE,      1'b0, 32'h0000_2000, 32'h0000_80FF, 5'd12, 4'b0001, 32'hFFFF_FFFF);
    do_load("lh",   HALF_WORD, 1'b0, 32'h0000_2002, 32'h8001_1234, 5'd13, 4'b1100, 32'hFFFF_8001);
    do_load("lhu",  HALF_WORD, 1'b1, 32'h0000_2002, 32'h8001_1234, 5'd14, 4'b1100, 32'h0000_8001);
    do_load("lw",   WORD,      1'b1, 32'h0000_2000, 32'h8001_1234, 5'd15, 4'b1111, 32'h8001_1234);

    do_fault("f_lw",   WORD,      32'h0000_3002, 5'd20);
    do_fault("f_size", 2'b10,     32'h0000_3000, 5'd21);
    do_fault("f_lh",   HALF_WORD, 32'h0000_3001, 5'd22);

    // Bus stalls for 5 cycles while a competing request is held on req_*.
    bus_req_ready = 1'b0;
    issue(1'b1, WORD, 1'b0, 32'h0000_4000, 32'h1122_3344, 5'd7);
    for (int i = 0; i < 5; i++) begin
      chk("bp_breq",  {31'b0, bus_req_valid}, 32'd1);
      chk("bp_addr",  bus_addr, 32'h0000_4000);
      chk("bp_be",    {28'b0, bus_be}, 32'h0000_000F);
      chk("bp_wdata", bus_wdata, 32'h1122_3344);
      chk("bp_we",    {31'b0, bus_we}, 32'd1);
      chk("bp_ready", {31'b0, req_ready}, 32'd0);
      chk("bp_rspv",  {31'b0, rsp_valid}, 32'd0);
      req_valid = 1'b1; req_write = 1'b0; req_size = BYTE;
      req_addr = 32'h0000_5001; req_rd = 5'd30;
      step();
    end
    req_valid = 1'b0;
    chk("bp_addr_end", bus_addr, 32'h0000_4000);
    bus_req_ready = 1'b1;
    step();
    chk("bp_rspv_done", {31'b0, rsp_valid}, 32'd1);
    chk("bp_rd_done",   {27'b0, rsp_rd}, 32'd7);
    chk("bp_rspw_done", {31'b0, rsp_write}, 32'd1);
    step();
    chk("bp_idle_busy", {31'b0, busy}, 32'd0);
    chk("bp_idle_breq", {31'b0, bus_req_valid}, 32'd0);

    // Async reset while waiting for read data.
    issue(1'b0, WORD, 1'b0, 32'h0000_2000, 32'h0, 5'd9);
    step();
    chk("ar_busy_pre", {31'b0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_busy",  {31'b0, busy}, 32'd0);
    chk("ar_breq",  {31'b0, bus_req_valid}, 32'd0);
    chk("ar_addr",  bus_addr, 32'h0);
    chk("ar_rspv",  {31'b0, rsp_valid}, 32'd0);
    chk("ar_rd",    {27'b0, rsp_rd}, 32'd0);
    chk("ar_ready", {31'b0, req_ready}, 32'd1);
    step();
    rst = 1'b0;
    bus_rsp_valid = 1'b1; bus_rdata = 32'hCAFE_F00D;
    step();
    bus_rsp_valid = 1'b0; bus_rdata = 32'h0;
    chk("ar_late_rspv", {31'b0, rsp_valid}, 32'd0);
    chk("ar_late_busy", {31'b0, busy}, 32'd0);
    step();
    chk("ar_late_rspv2", {31'b0, rsp_valid}, 32'd0);
    do_load("ar_lb", BYTE, 1'b0, 32'h0000_2003, 32'h7F00_0000, 5'd8, 4'b1000, 32'h0000_007F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
